// File: rtl/switch_debouncer_if.sv
// Switch debouncer bus: raw switch levels in, clean levels and edge pulses out.
interface switch_debouncer_if #(
    parameter int WIDTH = 6
);
    logic [WIDTH-1:0] SW;
    logic [WIDTH-1:0] sw_stable;
    logic [WIDTH-1:0] sw_rise;
    logic [WIDTH-1:0] sw_fall;
    logic             any_change;

    // Debouncer side
    modport slave (
        input  SW,
        output sw_stable, sw_rise, sw_fall, any_change
    );

    // Switch source / display consumer side
    modport master (
        output SW,
        input  sw_stable, sw_rise, sw_fall, any_change
    );
endinterface

// File: rtl/switch_debouncer.sv
// Slide-switch conditioner: per-bit 2-flop synchroniser, stable-count debounce,
// registered rise/fall pulses and a combined change pulse.

// One switch: synchroniser, restart-on-bounce counter, clean level and pulses.
module switch_debouncer_lane #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
    input  logic clock,
    input  logic reset,
    input  logic sw_raw,
    output logic stable,
    output logic rise,
    output logic fall,
    output logic accept
);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1;
    logic             sync2;
    logic [CNT_W-1:0] cnt;

    // The new level has now been seen for DEBOUNCE_CYCLES edges in a row.
    assign accept = (sync2 != stable) && (cnt == CNT_MAX);

    // Two-flop synchroniser, nothing between the stages.
    always_ff @(posedge clock) begin
        if (reset) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
        end else begin
            sync1 <= sw_raw;
            sync2 <= sync1;
        end
    end

    // Count while the synchronised level differs; any bounce restarts from zero.
    always_ff @(posedge clock) begin
        if (reset) begin
            cnt    <= '0;
            stable <= 1'b0;
            rise   <= 1'b0;
            fall   <= 1'b0;
        end else begin
            rise <= accept & sync2;
            fall <= accept & ~sync2;
            if (sync2 == stable) begin
                cnt <= '0;
            end else if (accept) begin
                stable <= sync2;
                cnt    <= '0;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end
endmodule

module switch_debouncer #(
    parameter int WIDTH           = 6,
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic                clock,
    input  logic                reset,
    switch_debouncer_if.slave   bus
);
    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

    logic [WIDTH-1:0] accept;

    // Bits are fully independent, one lane each.
    for (genvar i = 0; i < WIDTH; i++) begin : g_lane
        switch_debouncer_lane #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .CNT_W           (CNT_W)
        ) u_lane (
            .clock  (clock),
            .reset  (reset),
            .sw_raw (bus.SW[i]),
            .stable (bus.sw_stable[i]),
            .rise   (bus.sw_rise[i]),
            .fall   (bus.sw_fall[i]),
            .accept (accept[i])
        );
    end

    // Registered alongside the lane pulses so all pulses line up.
    always_ff @(posedge clock) begin
        if (reset) begin
            bus.any_change <= 1'b0;
        end else begin
            bus.any_change <= |accept;
        end
    end
endmodule

// File: tb/tb_switch_debouncer.sv
// Debouncer bench: directed scenarios plus random switch activity, every cycle
// compared against a sliding-window reference model through a scoreboard queue.
module tb_switch_debouncer;
    localparam int W = 6;
    localparam int N = 4;

    logic clock = 1'b0;
    logic reset = 1'b1;

    switch_debouncer_if #(.WIDTH(W)) sw_if();

    switch_debouncer #(
        .WIDTH           (W),
        .DEBOUNCE_CYCLES (N)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (sw_if.slave)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [W-1:0] stable;
        logic [W-1:0] rise;
        logic [W-1:0] fall;
        logic         any;
    } exp_t;

    exp_t sbq[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    endtask

    // Reference model: a bit is accepted when the synchronised level seen at the
    // last N edges (all after the latest reset/acceptance of that bit) disagrees
    // with the clean level. Synchronised level = SW delayed by two edges.
    logic [W-1:0] m_s1 = '0, m_s2 = '0, m_stable = '0;
    logic [W-1:0] s2hist[$];
    int           edge_no = 0;
    int           last_evt[W];
    exp_t         m_e;
    logic [W-1:0] m_v, m_acc;
    logic         m_ok;

    always @(posedge clock) begin
        edge_no++;
        m_v = m_s2;
        s2hist.push_back(m_v);
        m_e = '0;
        if (reset) begin
            m_s1 = '0;
            m_s2 = '0;
            m_stable = '0;
            for (int i = 0; i < W; i++) last_evt[i] = edge_no;
        end else begin
            m_acc = '0;
            for (int i = 0; i < W; i++) begin
                if (edge_no - last_evt[i] >= N) begin
                    m_ok = 1'b1;
                    for (int j = edge_no - N + 1; j <= edge_no; j++)
                        if (s2hist[j-1][i] == m_stable[i]) m_ok = 1'b0;
                    m_acc[i] = m_ok;
                end
            end
            for (int i = 0; i < W; i++) if (m_acc[i]) last_evt[i] = edge_no;
            m_e.rise = m_acc & m_v;
            m_e.fall = m_acc & ~m_v;
            m_e.any  = |m_acc;
            m_stable = m_stable ^ m_acc;
            m_s2 = m_s1;
            m_s1 = sw_if.SW;
        end
        m_e.stable = m_stable;
        sbq.push_back(m_e);
    end

    // Monitor: compare DUT outputs to the oldest expectation, away from the edge.
    exp_t mon_e;
    always @(negedge clock) begin
        if (sbq.size() > 0) begin
            mon_e = sbq.pop_front();
            check("sb_stable", sw_if.sw_stable, mon_e.stable);
            check("sb_rise", sw_if.sw_rise, mon_e.rise);
            check("sb_fall", sw_if.sw_fall, mon_e.fall);
            check("sb_any", W'(sw_if.any_change), W'(mon_e.any));
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clock);
        #2;
    endtask

    initial begin
        int t;
        sw_if.SW = 6'b101010;
        reset = 1'b1;

        // 1: reset held three edges, switches already high on odd bits
        step(3);
        reset = 1'b0;
        step(5);
        check("t1_early", sw_if.sw_stable, 6'b000000);
        step(1);
        check("t1_stable", sw_if.sw_stable, 6'b101010);
        check("t1_rise", sw_if.sw_rise, 6'b101010);
        step(1);
        check("t1_rise_end", sw_if.sw_rise, 6'b000000);

        // 2: clean rising edge on bit 2
        sw_if.SW[2] = 1'b1;
        step(5);
        check("t2_before", sw_if.sw_stable, 6'b101010);
        step(1);
        check("t2_stable", sw_if.sw_stable, 6'b101110);
        check("t2_rise", sw_if.sw_rise, 6'b000100);
        check("t2_any", W'(sw_if.any_change), W'(1));
        step(1);
        check("t2_rise_end", sw_if.sw_rise, 6'b000000);
        check("t2_any_end", W'(sw_if.any_change), W'(0));

        // 3: bounce on bit 0, then hold high
        for (int k = 0; k < 4; k++) begin
            sw_if.SW[0] = ~k[0];
            step(2);
        end
        sw_if.SW[0] = 1'b1;
        step(10);
        check("t3_stable", sw_if.sw_stable, 6'b101111);

        // 4: simultaneous rise and fall
        sw_if.SW = 6'b000011;
        step(10);
        sw_if.SW = 6'b001100;
        step(6);
        check("t4_fall", sw_if.sw_fall, 6'b000011);
        check("t4_rise", sw_if.sw_rise, 6'b001100);
        check("t4_any", W'(sw_if.any_change), W'(1));
        step(4);

        // 5: reset in the middle of a count on bit 5
        sw_if.SW[5] = 1'b1;
        step(4);
        reset = 1'b1;
        step(2);
        reset = 1'b0;
        check("t5_reset", sw_if.sw_stable, 6'b000000);
        step(5);
        check("t5_wait", sw_if.sw_stable, 6'b000000);
        step(1);
        check("t5_stable", sw_if.sw_stable, 6'b101100);
        check("t5_rise", sw_if.sw_rise, 6'b101100);
        step(4);

        // 6: N-1 glitch rejected, N-clock glitch accepted
        sw_if.SW[4] = 1'b1;
        step(3);
        sw_if.SW[4] = 1'b0;
        step(8);
        check("t6_short", sw_if.sw_stable, 6'b101100);
        sw_if.SW[4] = 1'b1;
        step(4);
        sw_if.SW[4] = 1'b0;
        step(2);
        check("t6_long", sw_if.sw_stable, 6'b111100);
        check("t6_rise", sw_if.sw_rise, 6'b010000);
        step(10);

        // Random activity: mixed short glitches, long holds, occasional reset
        repeat (300) begin
            t = $urandom_range(0, 99);
            reset = (t < 3);
            if (t < 60) sw_if.SW = W'($urandom);
            step($urandom_range(1, 6));
        end
        reset = 1'b0;
        step(20);

        t = 0;
        while (sbq.size() > 0 && t < 10) begin
            @(negedge clock);
            t++;
        end
        #1;
        check("drain", W'(sbq.size()), W'(0));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
